cla_32: RTL and testbench

- 32-bit two-level carry-lookahead adder with registered outputs; the datapath adder primitive of the RISC core's ALU.
- Computes a + b + cin; registers sum, carry-out and signed-overflow on the rising clock edge.
- Carry logic is hierarchical lookahead (no group-to-group ripple) so the combinational depth stays logarithmic.

---
 rtl/cla_32.sv | 64 ++++++
 tb/tb_cla_32.sv | 91 +++++++++
 2 files changed

// File: rtl/cla_32.sv
// cla_32: 32-bit two-level carry-lookahead adder with registered sum, carry-out and signed overflow.
module cla_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        in_valid,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow,
  output logic        out_valid
);
  logic [31:0] g, p, c, sum_d, sum_q;
  logic [7:0]  gg, gp;
  logic [8:0]  cg;
  logic        t, cout_q, overflow_q, out_valid_q;
  always_comb begin
    g = a & b;
    p = a ^ b;
    t = 1'b0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Each group carry is an independent sum of products over lower groups, not a chain.
    cg[0] = cin;
    for (int k = 0; k < 8; k++) begin
      cg[k+1] = cin;
      for (int m = 0; m <= k; m++) cg[k+1] = cg[k+1] & gp[m];
      for (int j = 0; j <= k; j++) begin
        t = gg[j];
        for (int m = j + 1; m <= k; m++) t = t & gp[m];
        cg[k+1] = cg[k+1] | t;
      end
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
    sum_d = p ^ c;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= 32'h0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cg[8];
      overflow_q  <= c[31] ^ cg[8];
      out_valid_q <= in_valid;
    end
  end
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_cla_32.sv
// tb_cla_32: scoreboard bench for cla_32; directed vectors plus a random sweep against a 33-bit model.
module tb_cla_32;
  logic        clk = 1'b0, rst = 1'b1, cin = 1'b0, in_valid = 1'b0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic [31:0] sum;
  logic        cout, overflow, out_valid;
  typedef struct packed {logic [31:0] s; logic co; logic ov;} exp_t;
  exp_t q[$];
  int errs = 0, checks = 0;

  cla_32 dut (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
              .sum(sum), .cout(cout), .overflow(overflow), .out_valid(out_valid));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                      input logic [31:0] es, input logic ec, input logic eo);
    a = ta; b = tb2; cin = tc; in_valid = 1'b1;
    q.push_back('{s: es, co: ec, ov: eo});
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out_valid: got sum=%h with empty scoreboard", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result{sum,cout,ovf}", {31'h0, sum, cout, overflow}, {31'h0, e.s, e.co, e.ov});
      end
    end
  end

  initial begin
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic        rc;
    #1;
    check("reset_async", {30'h0, sum, cout, overflow, out_valid}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", {30'h0, sum, cout, overflow, out_valid}, 64'h0);
    rst = 1'b0;
    send(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk); send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk); send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk); send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk); send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    @(negedge clk); send(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk); send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    @(negedge clk); send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    @(negedge clk);
    a = 32'd3; b = 32'd4; cin = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("no_valid_still_adds", {31'h0, sum, out_valid}, {31'h0, 32'd7, 1'b0});
    @(negedge clk); send(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
    @(negedge clk);
    a = 32'd5; b = 32'd5; cin = 1'b0; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 check("reset_mid_immediate", {30'h0, sum, cout, overflow, out_valid}, 64'h0);
    @(posedge clk); #1;
    check("reset_mid_held", {30'h0, sum, cout, overflow, out_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    send(32'd1, 32'd2, 1'b1, 32'd4, 1'b0, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
      r = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      send(ra, rb, rc, r[31:0], r[32], (ra[31] == rb[31]) && (r[31] != ra[31]));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
